// File: rtl/echo_conditioner.sv
// Echo front-end: synchronises and deglitches the raw echo pin, gates it with the
// trigger-armed window, force-terminates stuck echoes and counts missing/spurious echoes.
module echo_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned GLITCH_CYCLES   = 25,
  parameter int unsigned ARM_TIMEOUT     = 1_500_000,
  parameter int unsigned MAX_ECHO_CYCLES = 1_450_000,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             echo_raw,
  input  logic             trig,
  input  logic             clr_counts,
  output logic             echo_clean,
  output logic             armed,
  output logic             echo_timeout,
  output logic             no_echo,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] spurious_count
);

  localparam int unsigned GF_W   = (GLITCH_CYCLES > 1)   ? $clog2(GLITCH_CYCLES)   : 1;
  localparam int unsigned WIN_W  = (ARM_TIMEOUT > 1)     ? $clog2(ARM_TIMEOUT)     : 1;
  localparam int unsigned ECHO_W = (MAX_ECHO_CYCLES > 1) ? $clog2(MAX_ECHO_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, BLANK} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   echo_s;
  logic [GF_W-1:0]        glitch_cnt;
  logic                   filt, filt_d, filt_rise, filt_fall;
  logic                   trig_d, trig_fall;
  logic [WIN_W-1:0]       win_cnt;
  logic [ECHO_W-1:0]      echo_cnt;
  logic                   win_end, echo_end;
  logic                   win_clr, win_inc, echo_clr, echo_inc;
  logic                   miss_evt, spur_evt, tmo_evt;

  assign echo_s    = sync[SYNC_STAGES-1];
  assign filt_rise = filt & ~filt_d;
  assign filt_fall = ~filt & filt_d;
  assign trig_fall = ~trig & trig_d;
  assign win_end   = (win_cnt == WIN_W'(ARM_TIMEOUT - 1));
  assign echo_end  = (echo_cnt == ECHO_W'(MAX_ECHO_CYCLES - 1));

  // Synchroniser, glitch filter and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      glitch_cnt <= '0;
      filt       <= 1'b0;
      filt_d     <= 1'b0;
      trig_d     <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], echo_raw};
      filt_d <= filt;
      trig_d <= trig;
      if (echo_s == filt) begin
        glitch_cnt <= '0;
      end else if (glitch_cnt == GF_W'(GLITCH_CYCLES - 1)) begin
        filt       <= ~filt;
        glitch_cnt <= '0;
      end else begin
        glitch_cnt <= glitch_cnt + GF_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; in ARMED a new trigger outranks the window expiry so the
  // fresh window is honoured (either way exactly one miss is recorded).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (filt_rise)      state_nxt = BLANK;
        else if (trig_fall) state_nxt = ARMED;
      end
      ARMED: begin
        if (filt_rise)      state_nxt = HIGH;
        else if (trig_fall) state_nxt = ARMED;
        else if (win_end)   state_nxt = IDLE;
      end
      HIGH: begin
        if (filt_fall)     state_nxt = IDLE;
        else if (echo_end) state_nxt = BLANK;
      end
      BLANK: begin
        if (!filt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath control decode
  always_comb begin
    win_clr  = 1'b0;
    win_inc  = 1'b0;
    echo_clr = 1'b0;
    echo_inc = 1'b0;
    miss_evt = 1'b0;
    spur_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state)
      IDLE: begin
        spur_evt = filt_rise;
        win_clr  = trig_fall & ~filt_rise;
      end
      ARMED: begin
        echo_clr = filt_rise;
        win_clr  = ~filt_rise & trig_fall;
        win_inc  = ~filt_rise & ~trig_fall;
        miss_evt = ~filt_rise & (trig_fall | win_end);
      end
      HIGH: begin
        echo_inc = 1'b1;
        tmo_evt  = ~filt_fall & echo_end;
      end
      default: ;
    endcase
  end

  // Counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt        <= '0;
      echo_cnt       <= '0;
      echo_clean     <= 1'b0;
      armed          <= 1'b0;
      echo_timeout   <= 1'b0;
      no_echo        <= 1'b0;
      miss_count     <= '0;
      spurious_count <= '0;
    end else begin
      if (win_clr)      win_cnt <= '0;
      else if (win_inc) win_cnt <= win_cnt + WIN_W'(1);
      if (echo_clr)      echo_cnt <= '0;
      else if (echo_inc) echo_cnt <= echo_cnt + ECHO_W'(1);
      echo_clean   <= (state_nxt == HIGH);
      armed        <= (state_nxt == ARMED);
      echo_timeout <= tmo_evt;
      no_echo      <= miss_evt;
      if (clr_counts)                      miss_count <= '0;
      else if (miss_evt && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
      if (clr_counts)                              spurious_count <= '0;
      else if (spur_evt && spurious_count != '1) spurious_count <= spurious_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/echo_conditioner.md
Name: echo_conditioner

Overview:
Front-end stage between the sensor echo pin and the echo-timing/distance stage. It synchronises the raw echo, rejects glitches, and passes only echoes that answer a trigger. It forces echoes that stay high too long back low, and reports missing and spurious echoes. Its echo_clean output drives the downstream echo input directly, on the same 50 MHz clock.

Parameters:
SYNC_STAGES, 2, flops in the echo_raw synchroniser (minimum 2)
GLITCH_CYCLES, 25, consecutive synced-level cycles needed to accept a level change (0.5 us)
ARM_TIMEOUT, 1_500_000, cycles after trig falls within which an echo must begin
MAX_ECHO_CYCLES, 1_450_000, maximum accepted echo-high duration (500 cm at 2900 cycles/cm)
CNT_W, 8, width of the diagnostic counters

Ports:
clk  in  1  50 MHz system clock
rst_n  in  1  reset, asynchronous, active-low
echo_raw  in  1  asynchronous sensor echo pin
trig  in  1  trigger pulse from the trigger generator (clk domain)
clr_counts  in  1  synchronous clear of miss_count and spurious_count
echo_clean  out  1  conditioned echo to the timing stage
armed  out  1  high while waiting for an echo
echo_timeout  out  1  one-cycle pulse when an echo is force-terminated
no_echo  out  1  one-cycle pulse when an armed window expires without an echo
miss_count  out  CNT_W  saturating count of no_echo events
spurious_count  out  CNT_W  saturating count of unarmed echo rises

Behaviour:
- Reset: asynchronous and active-low. Clears all flops. All outputs are 0 during reset. FSM state is IDLE. The synchroniser and filter level are 0.
- Synchroniser: a SYNC_STAGES-deep flop chain on echo_raw, giving echo_s.
- Glitch filter, filt level:
  - A counter increments while echo_s != filt and resets to 0 when they are equal.
  - When the counter reaches GLITCH_CYCLES-1 while still mismatched, filt toggles and the counter clears.
  - A stable raw edge therefore reaches filt SYNC_STAGES+GLITCH_CYCLES edges after the first edge that samples it.
  - Pulses or gaps shorter than GLITCH_CYCLES cycles are dropped entirely.
- Trigger: trig_fall is trig low while the previously registered trig was high. No synchroniser is used on trig.
- FSM states:
  - IDLE: trig_fall moves to ARMED and loads the window counter with 0. A filt rising edge increments spurious_count and moves to BLANK.
  - ARMED:
    - armed = 1 and the window counter increments.
    - A filt rising edge moves to HIGH and loads the echo counter with 0. This has priority over the timeout and over trig_fall in the same cycle.
    - If the window counter reaches ARM_TIMEOUT-1: pulse no_echo, increment miss_count, go to IDLE.
    - trig_fall while ARMED counts as a miss: pulse no_echo, increment miss_count, reload the window, stay ARMED.
  - HIGH:
    - echo_clean = 1 and the echo counter increments.
    - A filt falling edge moves to IDLE, with echo_clean = 0 from the next cycle.
    - If the echo counter reaches MAX_ECHO_CYCLES-1: pulse echo_timeout, echo_clean = 0 from the next cycle, go to BLANK.
    - trig_fall is ignored.
  - BLANK: echo_clean = 0. Waits for filt = 0, then goes to IDLE. trig_fall is ignored.
- echo_clean is a registered output: high exactly during the HIGH state, with one cycle of latency after the filt edge. Total raw-to-echo_clean latency is SYNC_STAGES+GLITCH_CYCLES+1 edges, identical for rise and fall, so echo width is preserved.
- Counters: saturate at 2^CNT_W-1 and never wrap. When clr_counts and an increment occur in the same cycle, clear wins.
- Reset mid-echo: echo_clean drops immediately. After release, a still-high echo_raw is seen as a filt rise in IDLE and is counted as spurious, then blanked.

Test Plan:
(Parameters for the bench: SYNC_STAGES=2, GLITCH_CYCLES=4, ARM_TIMEOUT=200, MAX_ECHO_CYCLES=100, CNT_W=4.)
1. Normal echo: pulse trig, then raise echo_raw 10 cycles after trig falls and hold it 50 cycles -> echo_clean rises 7 edges after the raw rise and is high for exactly 50 cycles. no_echo, echo_timeout and both counters stay 0.
2. Glitch rejection: while ARMED, apply echo_raw high for 3 cycles -> echo_clean stays 0. A subsequent 4-cycle pulse produces a 4-cycle echo_clean.
3. Missing echo: trig fall with no echo -> armed high for 200 cycles, a single no_echo pulse, miss_count=1. Repeat 20 times -> miss_count saturates at 15. Assert clr_counts -> 0.
4. Stuck echo: armed echo held high for 300 cycles -> echo_clean high for 100 cycles, one echo_timeout pulse, then 0 until echo_raw falls. The next trig re-arms normally.
5. Spurious echo: echo_raw pulse of 20 cycles with no prior trig -> echo_clean stays 0 and spurious_count=1.
6. Edge cases:
   - Second trig fall while ARMED -> one no_echo pulse, miss_count+1, window restarts and a later echo passes.
   - Reset asserted mid-echo -> echo_clean=0 immediately.
   - echo_raw still high at reset release -> spurious_count=1, no echo_clean.
